// File: rtl/sram_arb_bridge_pkg.sv
// Shared types and constants for the SRAM arbitration bridge.
// Holds the port FSM state encoding, requester/region identifiers, the
// address-region constants and the value returned by unmapped reads.
package sram_arb_bridge_pkg;

  typedef enum logic [2:0] {
    PS_IDLE    = 3'd0,
    PS_RD      = 3'd1,
    PS_WSETUP  = 3'd2,
    PS_WSTROBE = 3'd3,
    PS_WHOLD   = 3'd4,
    PS_DONE    = 3'd5
  } port_state_t;

  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } requester_t;

  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_BASE = 2'd1,
    RGN_EXT  = 2'd2
  } region_t;

  localparam logic [9:0]  REGION_BASE    = 10'h200;
  localparam logic [9:0]  REGION_EXT     = 10'h201;
  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

  // Map the top ten address bits onto a target RAM.
  function automatic region_t decode_region(input logic [9:0] hi);
    region_t r;
    r = RGN_NONE;
    if (hi == REGION_BASE) r = RGN_BASE;
    else if (hi == REGION_EXT) r = RGN_EXT;
    return r;
  endfunction

endpackage

// File: rtl/sram_port_ctrl.sv
// Purpose: pin-level access sequencer for one asynchronous SRAM.
// Latency: read = RD_CYC+1 cycles from start to done, write = WR_CYC+3.
// Backpressure: start is only honoured while idle; the caller holds off otherwise.
// Ports: start/start_we/start_addr/start_wdata launch an access (captured on
// the start cycle); idle/done/rd_latch report progress; ram_* drive the SRAM.
module sram_port_ctrl
  import sram_arb_bridge_pkg::*;
#(
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  start_we,
  input  logic [19:0] start_addr,
  input  logic [31:0] start_wdata,
  output logic        idle,
  output logic        done,
  output logic        rd_latch,
  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [31:0] ram_dout,
  output logic        ram_doe
);

  localparam logic [3:0] RD_LAST = 4'(RD_CYC - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_CYC - 1);

  port_state_t state, state_nxt;
  logic [3:0]  cnt;
  logic [19:0] addr_q;
  logic [3:0]  be_n_q;
  logic [31:0] dout_q;

  // State register; reset is asynchronous so pins drop to idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PS_IDLE;
    else     state <= state_nxt;
  end

  // Dwell counter restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= 4'd0;
    else if (state != state_nxt) cnt <= 4'd0;
    else                         cnt <= cnt + 4'd1;
  end

  // Access parameters are frozen at start so the requester may move on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      be_n_q <= 4'hF;
      dout_q <= '0;
    end else if (start && state == PS_IDLE) begin
      addr_q <= start_addr;
      be_n_q <= ~start_we;
      dout_q <= start_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PS_IDLE:    if (start) state_nxt = (start_we == 4'b0000) ? PS_RD : PS_WSETUP;
      PS_RD:      if (cnt == RD_LAST) state_nxt = PS_DONE;
      PS_WSETUP:  state_nxt = PS_WSTROBE;
      PS_WSTROBE: if (cnt == WR_LAST) state_nxt = PS_WHOLD;
      PS_WHOLD:   state_nxt = PS_DONE;
      PS_DONE:    state_nxt = PS_IDLE;
      default:    state_nxt = PS_IDLE;
    endcase
  end

  always_comb begin
    idle     = (state == PS_IDLE);
    done     = (state == PS_DONE);
    rd_latch = (state == PS_RD) && (cnt == RD_LAST);
    ram_addr = addr_q;
    ram_dout = dout_q;
    ram_be_n = 4'hF;
    ram_ce_n = 1'b1;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    ram_doe  = 1'b0;
    case (state)
      PS_RD: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
        ram_be_n = 4'h0;
      end
      // Data is driven one cycle either side of the strobe for setup/hold.
      PS_WSETUP, PS_WHOLD: begin
        ram_ce_n = 1'b0;
        ram_be_n = be_n_q;
        ram_doe  = 1'b1;
      end
      PS_WSTROBE: begin
        ram_ce_n = 1'b0;
        ram_be_n = be_n_q;
        ram_doe  = 1'b1;
        ram_we_n = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_arb_bridge.sv
// Purpose: route inst/data SRAM-style requests to two external SRAMs (base, ext).
// Latency: read RD_CYC+1, write WR_CYC+3 cycles from grant; unmapped 1 cycle.
// Backpressure: a request to a busy RAM waits (en held) with ready low.
// Ports: inst_sram_* / data_sram_* requester side (en held until ready pulse);
// base_ram_* / ext_ram_* SRAM pins, tristate resolved above via *_doe.
module sram_arb_bridge
  import sram_arb_bridge_pkg::*;
#(
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_ready,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_ready,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  output logic [31:0] base_ram_dout,
  input  logic [31:0] base_ram_din,
  output logic        base_ram_doe,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n,
  output logic [31:0] ext_ram_dout,
  input  logic [31:0] ext_ram_din,
  output logic        ext_ram_doe
);

  region_t    inst_rgn, data_rgn;
  logic       inst_busy, data_busy;
  logic       inst_req_base, inst_req_ext, data_req_base, data_req_ext;
  logic       base_gnt_inst, base_gnt_data, ext_gnt_inst, ext_gnt_data;
  logic       base_start, ext_start;
  logic       base_idle, base_done, base_rd_latch;
  logic       ext_idle, ext_done, ext_rd_latch;
  requester_t base_owner, ext_owner;
  logic       base_last_data, ext_last_data;
  logic       inst_abort, data_abort;
  logic       inst_un_start, data_un_start, inst_un_done, data_un_done;
  logic       inst_map_done, data_map_done;
  logic [3:0]  base_we_sel, ext_we_sel;
  logic [19:0] base_addr_sel, ext_addr_sel;
  logic [31:0] base_wdata_sel, ext_wdata_sel;
  logic        unused_addr_bits;

  // Word addressing: the byte offset never reaches the pins.
  assign unused_addr_bits = ^{inst_sram_addr[1:0], data_sram_addr[1:0]};

  assign inst_rgn = decode_region(inst_sram_addr[31:22]);
  assign data_rgn = decode_region(data_sram_addr[31:22]);

  // A requester owning an access anywhere (including DONE) issues nothing new.
  assign inst_busy = (!base_idle && base_owner == REQ_INST) ||
                     (!ext_idle  && ext_owner  == REQ_INST);
  assign data_busy = (!base_idle && base_owner == REQ_DATA) ||
                     (!ext_idle  && ext_owner  == REQ_DATA);

  assign inst_req_base = inst_sram_en && !inst_busy && inst_rgn == RGN_BASE;
  assign inst_req_ext  = inst_sram_en && !inst_busy && inst_rgn == RGN_EXT;
  assign data_req_base = data_sram_en && !data_busy && data_rgn == RGN_BASE;
  assign data_req_ext  = data_sram_en && !data_busy && data_rgn == RGN_EXT;

  // Data wins a tie unless this port's previous grant already went to data.
  assign base_gnt_data = base_idle && data_req_base && (!inst_req_base || !base_last_data);
  assign base_gnt_inst = base_idle && inst_req_base && !base_gnt_data;
  assign ext_gnt_data  = ext_idle  && data_req_ext  && (!inst_req_ext  || !ext_last_data);
  assign ext_gnt_inst  = ext_idle  && inst_req_ext  && !ext_gnt_data;

  assign base_start = base_gnt_inst || base_gnt_data;
  assign ext_start  = ext_gnt_inst  || ext_gnt_data;

  assign base_we_sel    = base_gnt_data ? data_sram_we          : inst_sram_we;
  assign base_addr_sel  = base_gnt_data ? data_sram_addr[21:2]  : inst_sram_addr[21:2];
  assign base_wdata_sel = base_gnt_data ? data_sram_wdata       : inst_sram_wdata;
  assign ext_we_sel     = ext_gnt_data  ? data_sram_we          : inst_sram_we;
  assign ext_addr_sel   = ext_gnt_data  ? data_sram_addr[21:2]  : inst_sram_addr[21:2];
  assign ext_wdata_sel  = ext_gnt_data  ? data_sram_wdata       : inst_sram_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_owner     <= REQ_INST;
      ext_owner      <= REQ_INST;
      base_last_data <= 1'b0;
      ext_last_data  <= 1'b0;
    end else begin
      if (base_start) begin
        base_owner     <= base_gnt_data ? REQ_DATA : REQ_INST;
        base_last_data <= base_gnt_data;
      end
      if (ext_start) begin
        ext_owner     <= ext_gnt_data ? REQ_DATA : REQ_INST;
        ext_last_data <= ext_gnt_data;
      end
    end
  end

  // A requester that drops en mid-access has abandoned it; the RAM cycle
  // still finishes but its completion is swallowed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_abort <= 1'b0;
      data_abort <= 1'b0;
    end else begin
      if (base_gnt_inst || ext_gnt_inst)      inst_abort <= 1'b0;
      else if (inst_busy && !inst_sram_en)    inst_abort <= 1'b1;
      if (base_gnt_data || ext_gnt_data)      data_abort <= 1'b0;
      else if (data_busy && !data_sram_en)    data_abort <= 1'b1;
    end
  end

  // Unmapped requests bypass the RAMs and complete on the following cycle.
  assign inst_un_start = inst_sram_en && !inst_busy && inst_rgn == RGN_NONE && !inst_un_done;
  assign data_un_start = data_sram_en && !data_busy && data_rgn == RGN_NONE && !data_un_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_un_done <= 1'b0;
      data_un_done <= 1'b0;
    end else begin
      inst_un_done <= inst_un_start;
      data_un_done <= data_un_start;
    end
  end

  assign inst_map_done = (base_done && base_owner == REQ_INST) ||
                         (ext_done  && ext_owner  == REQ_INST);
  assign data_map_done = (base_done && base_owner == REQ_DATA) ||
                         (ext_done  && ext_owner  == REQ_DATA);

  assign inst_sram_ready = (inst_map_done && !inst_abort) || inst_un_done;
  assign data_sram_ready = (data_map_done && !data_abort) || data_un_done;

  // Read data is latched straight from the pins on the last OE cycle so it
  // is already valid while ready pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_sram_rdata <= '0;
    end else if (inst_un_start && inst_sram_we == 4'b0000) begin
      inst_sram_rdata <= UNMAPPED_RDATA;
    end else if (base_rd_latch && base_owner == REQ_INST && !inst_abort) begin
      inst_sram_rdata <= base_ram_din;
    end else if (ext_rd_latch && ext_owner == REQ_INST && !inst_abort) begin
      inst_sram_rdata <= ext_ram_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sram_rdata <= '0;
    end else if (data_un_start && data_sram_we == 4'b0000) begin
      data_sram_rdata <= UNMAPPED_RDATA;
    end else if (base_rd_latch && base_owner == REQ_DATA && !data_abort) begin
      data_sram_rdata <= base_ram_din;
    end else if (ext_rd_latch && ext_owner == REQ_DATA && !data_abort) begin
      data_sram_rdata <= ext_ram_din;
    end
  end

  sram_port_ctrl #(.RD_CYC(RD_CYC), .WR_CYC(WR_CYC)) u_base (
    .clk         (clk),
    .rst         (reset),
    .start       (base_start),
    .start_we    (base_we_sel),
    .start_addr  (base_addr_sel),
    .start_wdata (base_wdata_sel),
    .idle        (base_idle),
    .done        (base_done),
    .rd_latch    (base_rd_latch),
    .ram_addr    (base_ram_addr),
    .ram_be_n    (base_ram_be_n),
    .ram_ce_n    (base_ram_ce_n),
    .ram_oe_n    (base_ram_oe_n),
    .ram_we_n    (base_ram_we_n),
    .ram_dout    (base_ram_dout),
    .ram_doe     (base_ram_doe)
  );

  sram_port_ctrl #(.RD_CYC(RD_CYC), .WR_CYC(WR_CYC)) u_ext (
    .clk         (clk),
    .rst         (reset),
    .start       (ext_start),
    .start_we    (ext_we_sel),
    .start_addr  (ext_addr_sel),
    .start_wdata (ext_wdata_sel),
    .idle        (ext_idle),
    .done        (ext_done),
    .rd_latch    (ext_rd_latch),
    .ram_addr    (ext_ram_addr),
    .ram_be_n    (ext_ram_be_n),
    .ram_ce_n    (ext_ram_ce_n),
    .ram_oe_n    (ext_ram_oe_n),
    .ram_we_n    (ext_ram_we_n),
    .ram_dout    (ext_ram_dout),
    .ram_doe     (ext_ram_doe)
  );

endmodule

// File: tb/tb_sram_arb_bridge.sv
// Directed bench for sram_arb_bridge with RD_CYC = WR_CYC = 2.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_sram_arb_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en, data_sram_en;
  logic [3:0]  inst_sram_we, data_sram_we;
  logic [31:0] inst_sram_addr, data_sram_addr, inst_sram_wdata, data_sram_wdata;
  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic        inst_sram_ready, data_sram_ready;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_doe;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_ram_doe;
  logic [31:0] base_ram_dout, ext_ram_dout;
  logic [31:0] base_ram_din, ext_ram_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arb_bridge #(.RD_CYC(2), .WR_CYC(2)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata), .inst_sram_ready(inst_sram_ready),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .data_sram_ready(data_sram_ready),
    .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
    .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n),
    .base_ram_we_n(base_ram_we_n), .base_ram_dout(base_ram_dout),
    .base_ram_din(base_ram_din), .base_ram_doe(base_ram_doe),
    .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
    .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n),
    .ext_ram_we_n(ext_ram_we_n), .ext_ram_dout(ext_ram_dout),
    .ext_ram_din(ext_ram_din), .ext_ram_doe(ext_ram_doe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_en = 0; inst_sram_we = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_en = 0; data_sram_we = 0; data_sram_addr = 0; data_sram_wdata = 0;
    base_ram_din = 32'h1234_5678;
    ext_ram_din  = 32'hCAFE_F00D;
    step(); step();

    // Reset state
    chk("rst_inst_rdata", inst_sram_rdata, 32'h0);
    chk("rst_data_rdata", data_sram_rdata, 32'h0);
    chk("rst_inst_ready", inst_sram_ready, 0);
    chk("rst_data_ready", data_sram_ready, 0);
    chk("rst_base_pins", {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_doe}, 4'b1110);
    chk("rst_ext_pins", {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_ram_doe}, 4'b1110);
    chk("rst_base_be_n", base_ram_be_n, 4'hF);
    chk("rst_base_addr", base_ram_addr, 20'h0);
    chk("rst_ext_dout", ext_ram_dout, 32'h0);
    reset = 1'b0;
    step();

    // Inst read from base: ready 3 cycles after grant
    inst_sram_en = 1; inst_sram_we = 0; inst_sram_addr = 32'h8000_0010;
    chk("rd_c0_ready", inst_sram_ready, 0);
    step();
    chk("rd_c1_addr", base_ram_addr, 20'h00004);
    chk("rd_c1_pins", {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_doe}, 4'b0010);
    chk("rd_c1_be_n", base_ram_be_n, 4'h0);
    chk("rd_c1_ready", inst_sram_ready, 0);
    step();
    chk("rd_c2_oe_n", base_ram_oe_n, 0);
    chk("rd_c2_ready", inst_sram_ready, 0);
    step();
    chk("rd_c3_ready", inst_sram_ready, 1);
    chk("rd_c3_rdata", inst_sram_rdata, 32'h1234_5678);
    chk("rd_c3_oe_n", base_ram_oe_n, 1);
    inst_sram_en = 0;
    step();
    chk("rd_c4_ready", inst_sram_ready, 0);
    chk("rd_c4_ce_n", base_ram_ce_n, 1);

    // Data write to ext: setup, two strobe cycles, hold, done at cycle 5
    data_sram_en = 1; data_sram_we = 4'b0011; data_sram_addr = 32'h8040_0004;
    data_sram_wdata = 32'hAABB_CCDD;
    step();
    chk("wr_c1_addr", ext_ram_addr, 20'h00001);
    chk("wr_c1_be_n", ext_ram_be_n, 4'b1100);
    chk("wr_c1_pins", {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_ram_doe}, 4'b0111);
    chk("wr_c1_dout", ext_ram_dout, 32'hAABB_CCDD);
    data_sram_wdata = 32'h0; data_sram_addr = 32'h8040_0100;
    step();
    chk("wr_c2_we_n", ext_ram_we_n, 0);
    chk("wr_c2_dout", ext_ram_dout, 32'hAABB_CCDD);
    chk("wr_c2_addr", ext_ram_addr, 20'h00001);
    step();
    chk("wr_c3_we_n", ext_ram_we_n, 0);
    step();
    chk("wr_c4_pins", {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_ram_doe}, 4'b0111);
    chk("wr_c4_dout", ext_ram_dout, 32'hAABB_CCDD);
    chk("wr_c4_ready", data_sram_ready, 0);
    step();
    chk("wr_c5_ready", data_sram_ready, 1);
    chk("wr_c5_doe", ext_ram_doe, 0);
    data_sram_en = 0; data_sram_we = 0;
    step();

    // Concurrent: inst -> base, data -> ext
    inst_sram_en = 1; inst_sram_addr = 32'h8000_0000;
    data_sram_en = 1; data_sram_addr = 32'h8040_0000;
    step();
    chk("cc_c1_ce_n", {base_ram_ce_n, ext_ram_ce_n}, 2'b00);
    step(); step();
    chk("cc_c3_ready", {inst_sram_ready, data_sram_ready}, 2'b11);
    chk("cc_c3_inst_rdata", inst_sram_rdata, 32'h1234_5678);
    chk("cc_c3_data_rdata", data_sram_rdata, 32'hCAFE_F00D);
    inst_sram_en = 0; data_sram_en = 0;
    step();

    // Three back-to-back conflicts on base: data (0x40), inst (0x20), data
    inst_sram_en = 1; inst_sram_addr = 32'h8000_0020;
    data_sram_en = 1; data_sram_addr = 32'h8000_0040;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("arb_c%0d_data_ready", k), data_sram_ready, (k == 3 || k == 11) ? 1 : 0);
      chk($sformatf("arb_c%0d_inst_ready", k), inst_sram_ready, (k == 7) ? 1 : 0);
      if (k == 1) chk("arb_c1_addr", base_ram_addr, 20'h00010);
      if (k == 5) chk("arb_c5_addr", base_ram_addr, 20'h00008);
      if (k == 11) begin
        inst_sram_en = 0; data_sram_en = 0;
      end
      step();
    end

    // Unmapped data read: ready next cycle, rdata 0, no pin activity
    data_sram_en = 1; data_sram_we = 0; data_sram_addr = 32'h9000_0000;
    chk("um_c0_ready", data_sram_ready, 0);
    step();
    chk("um_c1_ready", data_sram_ready, 1);
    chk("um_c1_rdata", data_sram_rdata, 32'h0);
    chk("um_c1_ce_n", {base_ram_ce_n, ext_ram_ce_n}, 2'b11);
    data_sram_en = 0;
    step();
    chk("um_c2_ready", data_sram_ready, 0);

    // Abandoned read: RAM cycle finishes, ready is swallowed
    data_sram_en = 1; data_sram_addr = 32'h8000_0000;
    step();
    data_sram_en = 0;
    step();
    chk("ab_c2_oe_n", base_ram_oe_n, 0);
    step();
    chk("ab_c3_ready", data_sram_ready, 0);
    step();

    // Reset during write strobe, then a normal read on the same RAM
    data_sram_en = 1; data_sram_we = 4'hF; data_sram_addr = 32'h8040_0008;
    data_sram_wdata = 32'h1111_2222;
    step(); step();
    chk("rs_c2_we_n", ext_ram_we_n, 0);
    reset = 1'b1; data_sram_en = 0; data_sram_we = 0;
    #1;
    chk("rs_async_pins", {ext_ram_ce_n, ext_ram_we_n, ext_ram_doe}, 3'b110);
    step();
    chk("rs_ready", data_sram_ready, 0);
    reset = 1'b0;
    step();
    inst_sram_en = 1; inst_sram_we = 0; inst_sram_addr = 32'h8040_0000;
    step(); step(); step();
    chk("rs_next_ready", inst_sram_ready, 1);
    chk("rs_next_rdata", inst_sram_rdata, 32'hCAFE_F00D);
    chk("rs_next_data_ready", data_sram_ready, 0);
    inst_sram_en = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arb_bridge.md
SRAM_ARB_BRIDGE -- requirements
Module: sram_arb_bridge

Interface
REQ-001 SHALL have parameter RD_CYC, default 2: cycles OE asserted before read data latch, legal range 1-15.
REQ-002 SHALL have parameter WR_CYC, default 2: cycles WE_n held low per write, legal range 1-15.
REQ-003 SHALL have port clk, input, 1 bit: single clock for the whole block.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports inst_sram_en/data_sram_en, input, 1 bit each: request valid, held until ready.
REQ-006 SHALL have ports inst_sram_we/data_sram_we, input, 4 bits each: byte write enables; 0000 means read.
REQ-007 SHALL have ports inst_sram_addr/data_sram_addr and inst_sram_wdata/data_sram_wdata, input, 32 bits each.
REQ-008 SHALL have ports inst_sram_rdata/data_sram_rdata, output, 32 bits each: registered read data.
REQ-009 SHALL have ports inst_sram_ready/data_sram_ready, output, 1 bit each: one-cycle completion pulse.
REQ-010 SHALL have ports base_ram_addr/ext_ram_addr, output, 20 bits each.
REQ-011 SHALL have ports base_ram_be_n/ext_ram_be_n, output, 4 bits each.
REQ-012 SHALL have ports {base,ext}_ram_ce_n, _oe_n and _we_n, output, 1 bit each, active-low.
REQ-013 SHALL have ports {base,ext}_ram_dout (output, 32 bits), _din (input, 32 bits) and _doe (output, 1 bit); the tristate is resolved at top level.

Function
REQ-014 Address decode SHALL be: addr[31:22]==0x200 selects base; addr[31:22]==0x201 selects ext; all other addresses are unmapped.
REQ-015 The ram_addr output SHALL be addr[21:2].
REQ-016 Each RAM SHALL have an independent port FSM with states IDLE, RD, WSETUP, WSTROBE, WHOLD, DONE.
REQ-017 Read: IDLE->RD; ce_n=0, oe_n=0, be_n=0000 for RD_CYC cycles; din is latched into rdata on the last RD cycle; then DONE.
REQ-018 Write: WSETUP (1 cycle; ce_n=0, we_n=1, doe=1, be_n=~we), then WSTROBE (we_n=0 for WR_CYC cycles), then WHOLD (1 cycle; we_n=1, doe still 1), then DONE.
REQ-019 DONE SHALL last 1 cycle and assert the owner's ready for exactly that cycle; the FSM then returns to IDLE, and a new grant is possible in the next cycle.
REQ-020 Read latency from grant cycle to ready SHALL be RD_CYC+1 cycles; write latency SHALL be WR_CYC+3 cycles.
REQ-021 Outside an access, the port SHALL drive ce_n=oe_n=we_n=1, doe=0 and be_n=1111.
REQ-022 When inst and data target different RAMs in the same cycle, both SHALL be granted concurrently.
REQ-023 When both target the same idle RAM, the port SHALL grant data, except when its previous grant was data, in which case it SHALL grant inst (alternating; no starvation).
REQ-024 A requester targeting a busy RAM SHALL wait, with no ready asserted.
REQ-025 An unmapped request SHALL complete with ready 1 cycle after en, rdata=0, and no RAM pins toggled.
REQ-026 The owner's address, we and wdata SHALL be captured at grant; later input changes SHALL not affect the access in flight.
REQ-027 An en deasserted before ready is a protocol violation; the in-flight access SHALL complete anyway and the ready SHALL be discarded.
REQ-028 rdata SHALL hold its value until the next read completion for that requester.

Reset
REQ-029 When reset asserts (including mid-access), all FSMs SHALL enter IDLE immediately.
REQ-030 Reset values SHALL be: ready=0, rdata=0, ce_n/oe_n/we_n=1, doe=0, be_n=1111, addr=0, dout=0, priority=data-first.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the region constants 0x200/0x201, and the unmapped read value.
REQ-032 The port FSM SHALL be one sub-module, sram_port_ctrl, instantiated twice; arbitration and decode SHALL live in the top.

Verification
REQ-033 Inst read 0x8000_0010 with base din=0x1234_5678 and RD_CYC=2 -> base_ram_addr=0x00004; inst_ready 3 cycles after grant; inst_rdata=0x1234_5678.
REQ-034 Data write 0x8040_0004, we=0011, wdata=0xAABB_CCDD -> ext_ram_be_n=1100; we_n low for exactly 2 cycles; dout stable over SETUP to HOLD; data_ready 5 cycles after grant.
REQ-035 Simultaneous inst to base and data to ext -> both RAMs active in the same cycle; both readies asserted.
REQ-036 Three back-to-back same-cycle conflicts on base -> grant order data, inst, data.
REQ-037 Data read 0x9000_0000 -> data_ready next cycle; rdata=0; all RAM pins idle.
REQ-038 Reset asserted during WSTROBE -> we_n=1 and doe=0 in the same cycle (asynchronous); no ready asserted; the next request is served normally.
